// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic MAC array result path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   ACC_W, N_MACS, IDX_W  default datapath geometry
//   fifo_entry_t          {idx, data} word stored in the result FIFO
//   lowest_set()          lowest-index set bit of a lane mask, with a found flag
package systolic_pkg;

   localparam int ACC_W  = 16;
   localparam int N_MACS = 4;
   localparam int IDX_W  = 2;

   // Lane index sits above the data so a packed entry reads as {idx, data}.
   typedef struct packed {
      logic [IDX_W-1:0]        idx;
      logic signed [ACC_W-1:0] data;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   // Returns {found, idx}. Scanning from the top down lets the last hit win,
   // which leaves the lowest set index in the result.
   function automatic logic [IDX_W:0] lowest_set(input logic [N_MACS-1:0] mask);
      logic [IDX_W:0] res;
      res = '0;
      for (int i = N_MACS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            res = {1'b1, IDX_W'(i)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with first-word fall-through head.
// Latency: a push is visible at pop_data on the edge after it is accepted.
// Backpressure: push is dropped when full unless a pop happens the same cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             synchronous flush (pointers and count to zero)
//   push, push_data write request and word
//   pop, pop_data   read request and head word (valid while !empty)
//   full, empty     status
//   count           occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage needs no reset: nothing is read until count says it was written.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !clr) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointer wrap is plain binary overflow.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/acc_result_collector.sv
// Collects per-lane MAC accumulator results on valid rising edges and serialises them through a FIFO.
// Latency: valid_in rise at edge N -> pending at N -> out_valid at N+1 (empty FIFO, lane has priority).
// Backpressure: out_ready low holds the head; full FIFO parks results in lane registers, a second result on a parked lane is dropped and sets overflow.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (wins over clear)
//   acc_in_0..acc_in_3       signed lane accumulator values
//   valid_in                 per-lane valid level, rising edge captures
//   clear                    synchronous flush of FIFO, pending lanes, frame mask, overflow
//   out_data/out_idx         FIFO head value and its lane (zero when empty)
//   out_valid/out_ready      head handshake
//   frame_done               1-cycle pulse when every lane has been captured once
//   overflow                 sticky lost-result flag
//   count                    FIFO occupancy
module acc_result_collector #(
   parameter int ACC_W  = systolic_pkg::ACC_W,
   parameter int N_MACS = systolic_pkg::N_MACS,
   parameter int DEPTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [ACC_W-1:0]      acc_in_0,
   input  logic signed [ACC_W-1:0]      acc_in_1,
   input  logic signed [ACC_W-1:0]      acc_in_2,
   input  logic signed [ACC_W-1:0]      acc_in_3,
   input  logic [N_MACS-1:0]            valid_in,
   input  logic                         clear,
   output logic signed [ACC_W-1:0]      out_data,
   output logic [1:0]                   out_idx,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         frame_done,
   output logic                         overflow,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   import systolic_pkg::fifo_entry_t;
   import systolic_pkg::IDX_W;
   import systolic_pkg::ENTRY_W;
   import systolic_pkg::lowest_set;

   logic signed [ACC_W-1:0] lane_acc [N_MACS];
   logic signed [ACC_W-1:0] hold     [N_MACS];
   logic signed [ACC_W-1:0] hold_nxt [N_MACS];

   logic [N_MACS-1:0] prev_valid;
   logic [N_MACS-1:0] cap_ev;
   logic [N_MACS-1:0] pending;
   logic [N_MACS-1:0] pending_nxt;
   logic [N_MACS-1:0] pushed;
   logic [N_MACS-1:0] seen;
   logic [N_MACS-1:0] seen_upd;

   logic [IDX_W:0]    sel;
   logic              sel_vld;
   logic [IDX_W-1:0]  sel_idx;
   logic              ovf_set;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   fifo_entry_t       push_entry;
   fifo_entry_t       head_entry;

   // Lane ports folded into an array so the rest of the block is lane-generic.
   for (genvar g = 0; g < N_MACS; g++) begin : g_lane
      if (g == 0) begin : g_l0
         assign lane_acc[g] = acc_in_0;
      end else if (g == 1) begin : g_l1
         assign lane_acc[g] = acc_in_1;
      end else if (g == 2) begin : g_l2
         assign lane_acc[g] = acc_in_2;
      end else if (g == 3) begin : g_l3
         assign lane_acc[g] = acc_in_3;
      end else begin : g_lx
         assign lane_acc[g] = '0;
      end
   end

   // A held-high level produces a single event: only 0->1 transitions count.
   assign cap_ev = valid_in & ~prev_valid;

   // Fixed priority: lowest pending lane goes to the FIFO first.
   assign sel     = lowest_set(pending);
   assign sel_vld = sel[IDX_W];
   assign sel_idx = sel[IDX_W-1:0];

   assign pop  = !fifo_empty && out_ready;
   assign push = sel_vld && !clear && (!fifo_full || pop);

   always_comb begin
      pushed = '0;
      if (push) begin
         pushed[sel_idx] = 1'b1;
      end
   end

   always_comb begin
      push_entry      = '0;
      push_entry.idx  = sel_idx;
      push_entry.data = hold[sel_idx];
   end

   // Lane holding update. Clearing the pushed lane first means a capture that
   // lands on the lane leaving this cycle re-latches cleanly instead of
   // counting as a lost result.
   always_comb begin
      pending_nxt = pending & ~pushed;
      ovf_set     = 1'b0;
      for (int i = 0; i < N_MACS; i++) begin
         hold_nxt[i] = hold[i];
         if (cap_ev[i]) begin
            if (pending_nxt[i]) begin
               ovf_set = 1'b1;
            end else begin
               hold_nxt[i]    = lane_acc[i];
               pending_nxt[i] = 1'b1;
            end
         end
      end
   end

   assign seen_upd = seen | cap_ev;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_valid <= '0;
         pending    <= '0;
         seen       <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         for (int i = 0; i < N_MACS; i++) begin
            hold[i] <= '0;
         end
      end else begin
         // Tracks valid_in even during clear, so lanes held high across a
         // flush do not fire again afterwards.
         prev_valid <= valid_in;
         if (clear) begin
            pending    <= '0;
            seen       <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
         end else begin
            pending  <= pending_nxt;
            hold     <= hold_nxt;
            overflow <= overflow | ovf_set;
            if (&seen_upd) begin
               seen       <= '0;
               frame_done <= 1'b1;
            end else begin
               seen       <= seen_upd;
               frame_done <= 1'b0;
            end
         end
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (clear),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   // Head is gated to zero when empty so idle outputs match the reset values.
   assign out_valid = !fifo_empty;
   assign out_data  = out_valid ? ACC_W'(head_entry.data) : '0;
   assign out_idx   = out_valid ? 2'(head_entry.idx) : 2'b00;

endmodule

// File: doc/acc_result_collector.md
ACC_RESULT_COLLECTOR -- requirements
Module: acc_result_collector

Interface
REQ-001 Parameter ACC_W, default 16, accumulator result width in bits (signed).
REQ-002 Parameter N_MACS, default 4, number of MAC lanes.
REQ-003 Parameter DEPTH, default 8, result FIFO entries (power of two, >= N_MACS).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 acc_in_0..acc_in_3  input  ACC_W each  signed MAC accumulator values, one port per lane.
REQ-008 valid_in  input  N_MACS  per-lane result-valid level from the systolic array.
REQ-009 clear  input  1  synchronous flush of all buffered results and flags.
REQ-010 out_data  output  ACC_W  signed result at FIFO head.
REQ-011 out_idx  output  2  lane index of out_data.
REQ-012 out_valid  output  1  FIFO head valid.
REQ-013 out_ready  input  1  downstream accepts head.
REQ-014 frame_done  output  1  one-cycle pulse when every lane has been captured once.
REQ-015 overflow  output  1  sticky lost-result flag.
REQ-016 count  output  clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-017 Capture: a lane capture event SHALL occur when valid_in[i]=1 and the registered previous valid_in[i]=0; a level held high SHALL produce exactly one event.
REQ-018 On a capture event the block SHALL latch acc_in_i into lane holding register i and set pending[i] on the same clock edge.
REQ-019 Capture event on a lane with pending[i] already set SHALL leave the held value unchanged, drop the new value, and set overflow.
REQ-020 Arbiter: each cycle the lowest-index pending lane SHALL be pushed as {idx, data} into the FIFO and its pending bit cleared, if push is permitted.
REQ-021 Push SHALL be permitted when count < DEPTH, or when count = DEPTH and a pop occurs in the same cycle.
REQ-022 A capture event on a lane being pushed in the same cycle SHALL re-latch and keep pending[i] set (no overflow).
REQ-023 Latency: valid_in rising sampled at edge N -> pending after N -> FIFO entry and out_valid=1 after N+1 when FIFO was empty and the lane has priority.
REQ-024 out_valid SHALL equal (count != 0); pop SHALL occur when out_valid and out_ready are both 1.
REQ-025 out_data/out_idx SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 FIFO order SHALL be strict first-in first-out; pointers wrap modulo DEPTH.
REQ-027 count SHALL increment on push-only, decrement on pop-only, hold on push+pop or neither.
REQ-028 Frame tracking: seen mask |= capture events each cycle; when the updated mask is all ones, frame_done SHALL pulse 1 cycle and the mask SHALL return to zero.
REQ-029 clear SHALL empty FIFO, zero pending, seen mask and overflow, and deassert frame_done on the next edge; the previous-valid register SHALL still update so held-high lanes do not retrigger.
REQ-030 Capture events in the clear cycle SHALL be discarded.
REQ-031 overflow SHALL be cleared only by rst or clear.

Reset
REQ-032 On rst: out_valid=0, out_data=0, out_idx=0, frame_done=0, overflow=0, count=0, pending=0, seen mask=0, FIFO pointers=0, previous-valid register=0.
REQ-033 rst asserted mid-operation SHALL discard all buffered and pending results; rst SHALL take priority over clear.

Structure
REQ-034 ACC_W, N_MACS and the FIFO entry type {idx, data} SHALL live in the shared package systolic_pkg.
REQ-035 The FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-036 Single lane: acc_in_0=25, valid_in=0001 rising, out_ready=1 -> out_valid two edges later with out_data=25, out_idx=0, count returns to 0.
REQ-037 Simultaneous: valid_in 0000->1111 with values 3,-7,12,100 -> outputs in order idx 0,1,2,3 with those values; frame_done pulses once.
REQ-038 Backpressure: out_ready=0, 8 captures across two frames -> count=8, data stable; 9th capture stays pending; raise out_ready -> all 9 emerge in order, overflow=0.
REQ-039 Overflow: out_ready=0, FIFO full, lane 2 pending, second valid_in[2] rising with 55 -> overflow=1, 55 never appears at output.
REQ-040 Held valid: valid_in[1] held high 20 cycles -> exactly one output for lane 1.
REQ-041 Clear/reset mid-stream: 5 entries buffered, assert clear -> count=0, out_valid=0, overflow=0 next cycle; repeat with rst -> all outputs at reset values.
